// File: rtl/apb_pkg.sv
// Shared types and constants for the APB requester.
// State encoding, default widths and response error code.
package apb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2,
        ST_RESP   = 2'd3
    } apb_state_e;

    localparam int APB_ADDR_W  = 32;
    localparam int APB_DATA_W  = 32;
    localparam int APB_TIMEOUT = 16;

    localparam logic RSP_OK  = 1'b0;
    localparam logic RSP_ERR = 1'b1;

    // A zero TIMEOUT still needs a one-bit counter to stay legal.
    function automatic int cnt_width(input int t);
        return (t < 1) ? 1 : $clog2(t + 1);
    endfunction

endpackage

// File: rtl/apb_wait_timer.sv
// Wait-state counter for the ACCESS phase.
// Clears on transfer start, saturates at TIMEOUT, flags expiry.
module apb_wait_timer
    import apb_pkg::*;
#(
    parameter int TIMEOUT = APB_TIMEOUT
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic inc,
    output logic expired
);

    localparam int CW = cnt_width(TIMEOUT);
    localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT);

    logic [CW-1:0] cnt;
    logic [CW:0]   cnt_inc;

    assign cnt_inc = {1'b0, cnt} + {{CW{1'b0}}, 1'b1};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc && (cnt != LIMIT)) begin
            cnt <= cnt_inc[CW-1:0];
        end
    end

    // Fires on the edge where this wait cycle makes the count reach TIMEOUT.
    assign expired = (TIMEOUT != 0) && inc
                     && (cnt_inc >= {1'b0, LIMIT});

endmodule

// File: rtl/apb_master.sv
// Single-outstanding APB requester: valid/ready command in,
// SETUP/ACCESS transfer out, valid/ready response back.
module apb_master
    import apb_pkg::*;
#(
    parameter int ADDR_W  = APB_ADDR_W,
    parameter int DATA_W  = APB_DATA_W,
    parameter int TIMEOUT = APB_TIMEOUT
) (
    input  logic              I_PCLK,
    input  logic              I_PRESET_N,
    input  logic              I_CMD_VALID,
    output logic              O_CMD_READY,
    input  logic              I_CMD_WRITE,
    input  logic [ADDR_W-1:0] I_CMD_ADDR,
    input  logic [DATA_W-1:0] I_CMD_WDATA,
    output logic              O_RSP_VALID,
    input  logic              I_RSP_READY,
    output logic [DATA_W-1:0] O_RSP_RDATA,
    output logic              O_RSP_ERR,
    output logic              O_PSEL,
    output logic              O_PENABLE,
    output logic              O_PWRITE,
    output logic [ADDR_W-1:0] O_PADDR,
    output logic [DATA_W-1:0] O_PWDATA,
    input  logic [DATA_W-1:0] I_PRDATA,
    input  logic              I_PREADY
);

    apb_state_e state;
    apb_state_e state_nx;

    logic accept;
    logic misaligned;
    logic timer_clr;
    logic timer_inc;
    logic expired;

    logic              cmd_ready_d;
    logic              rsp_valid_d;
    logic              psel_d;
    logic              penable_d;
    logic              pwrite_d;
    logic              err_d;
    logic [ADDR_W-1:0] paddr_d;
    logic [DATA_W-1:0] pwdata_d;
    logic [DATA_W-1:0] rdata_d;

    assign accept     = (state == ST_IDLE) && I_CMD_VALID && O_CMD_READY;
    assign misaligned = |I_CMD_ADDR[1:0];
    assign timer_clr  = accept && !misaligned;
    assign timer_inc  = (state == ST_ACCESS) && !I_PREADY;

    apb_wait_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_timer (
        .clk     (I_PCLK),
        .rst_n   (I_PRESET_N),
        .clr     (timer_clr),
        .inc     (timer_inc),
        .expired (expired)
    );

    always_ff @(posedge I_PCLK or negedge I_PRESET_N) begin
        if (!I_PRESET_N) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            ST_IDLE: begin
                if (accept) begin
                    state_nx = misaligned ? ST_RESP : ST_SETUP;
                end
            end
            ST_SETUP: begin
                state_nx = ST_ACCESS;
            end
            ST_ACCESS: begin
                if (I_PREADY || expired) begin
                    state_nx = ST_RESP;
                end
            end
            ST_RESP: begin
                if (I_RSP_READY) begin
                    state_nx = ST_IDLE;
                end
            end
        endcase
    end

    // Next values for the output registers, derived from the next state.
    always_comb begin
        cmd_ready_d = (state_nx == ST_IDLE);
        rsp_valid_d = (state_nx == ST_RESP);
        psel_d      = (state_nx == ST_SETUP) || (state_nx == ST_ACCESS);
        penable_d   = (state_nx == ST_ACCESS);
        pwrite_d    = O_PWRITE;
        paddr_d     = O_PADDR;
        pwdata_d    = O_PWDATA;
        rdata_d     = O_RSP_RDATA;
        err_d       = O_RSP_ERR;
        if (accept) begin
            pwrite_d = I_CMD_WRITE;
            paddr_d  = I_CMD_ADDR;
            pwdata_d = I_CMD_WDATA;
            if (misaligned) begin
                rdata_d = '0;
                err_d   = RSP_ERR;
            end
        end
        if (state == ST_ACCESS) begin
            if (I_PREADY) begin
                rdata_d = O_PWRITE ? '0 : I_PRDATA;
                err_d   = RSP_OK;
            end else if (expired) begin
                rdata_d = '0;
                err_d   = RSP_ERR;
            end
        end
    end

    always_ff @(posedge I_PCLK or negedge I_PRESET_N) begin
        if (!I_PRESET_N) begin
            O_CMD_READY <= 1'b0;
            O_RSP_VALID <= 1'b0;
            O_RSP_RDATA <= '0;
            O_RSP_ERR   <= 1'b0;
            O_PSEL      <= 1'b0;
            O_PENABLE   <= 1'b0;
            O_PWRITE    <= 1'b0;
            O_PADDR     <= '0;
            O_PWDATA    <= '0;
        end else begin
            O_CMD_READY <= cmd_ready_d;
            O_RSP_VALID <= rsp_valid_d;
            O_RSP_RDATA <= rdata_d;
            O_RSP_ERR   <= err_d;
            O_PSEL      <= psel_d;
            O_PENABLE   <= penable_d;
            O_PWRITE    <= pwrite_d;
            O_PADDR     <= paddr_d;
            O_PWDATA    <= pwdata_d;
        end
    end

endmodule

// File: tb/tb_apb_master.sv
// Bench for apb_master: transfer-level model, cycle compare,
// a behavioural APB slave with wait states and directed vectors.
module tb_apb_master;
    import apb_pkg::*;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int TO = 16;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          cmd_valid;
    logic          cmd_ready;
    logic          cmd_write;
    logic [AW-1:0] cmd_addr;
    logic [DW-1:0] cmd_wdata;
    logic          rsp_valid;
    logic          rsp_ready;
    logic [DW-1:0] rsp_rdata;
    logic          rsp_err;
    logic          psel;
    logic          penable;
    logic          pwrite;
    logic [AW-1:0] paddr;
    logic [DW-1:0] pwdata;
    logic [DW-1:0] prdata;
    logic          pready;

    apb_master #(
        .ADDR_W  (AW),
        .DATA_W  (DW),
        .TIMEOUT (TO)
    ) dut (
        .I_PCLK      (clk),
        .I_PRESET_N  (rst_n),
        .I_CMD_VALID (cmd_valid),
        .O_CMD_READY (cmd_ready),
        .I_CMD_WRITE (cmd_write),
        .I_CMD_ADDR  (cmd_addr),
        .I_CMD_WDATA (cmd_wdata),
        .O_RSP_VALID (rsp_valid),
        .I_RSP_READY (rsp_ready),
        .O_RSP_RDATA (rsp_rdata),
        .O_RSP_ERR   (rsp_err),
        .O_PSEL      (psel),
        .O_PENABLE   (penable),
        .O_PWRITE    (pwrite),
        .O_PADDR     (paddr),
        .O_PWDATA    (pwdata),
        .I_PRDATA    (prdata),
        .I_PREADY    (pready)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string nm,
                       input logic [63:0] got,
                       input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)",
                     nm, got, exp, cyc);
        end
    endtask

    // Behavioural slave: configurable wait states or stuck low.
    int          waits = 0;
    bit          stuck = 1'b0;
    int          swait = 0;
    logic [31:0] smem [256];

    assign pready = psel && penable && !stuck && (swait >= waits);
    assign prdata = smem[paddr[9:2]];

    always @(posedge clk) begin
        if (psel && !penable) swait <= 0;
        else if (psel && penable && !pready) swait <= swait + 1;
        if (psel && penable && pready && pwrite)
            smem[paddr[9:2]] <= pwdata;
    end

    // Transfer model: accept edge A, response after edge A+x.
    logic [31:0] mmem [256];
    bit          in_rst = 1'b1;
    bit          rdy_exp = 1'b0;
    bit          act = 1'b0;
    bit          apb = 1'b0;
    int          A = 0;
    int          x = 0;
    logic [31:0] e_addr;
    logic [31:0] e_wdata;
    logic [31:0] e_rd;
    bit          e_wr;
    bit          e_err;

    int          k;
    int          psel_n;
    int          pen_n;
    int          rv_n;
    int          first_rv;
    logic [31:0] cap_rd;
    logic        cap_err;

    always @(negedge clk) begin
        if (in_rst) begin
            chk("rst_psel", psel, 0);
            chk("rst_penable", penable, 0);
            chk("rst_rsp_valid", rsp_valid, 0);
            chk("rst_cmd_ready", cmd_ready, 0);
            chk("rst_paddr", paddr, 0);
            chk("rst_rdata", rsp_rdata, 0);
        end else if (act) begin
            k = cyc - A;
            chk("psel", psel, apb && (k < x));
            chk("penable", penable, apb && (k >= 1) && (k < x));
            chk("rsp_valid", rsp_valid, k >= x);
            chk("cmd_ready_busy", cmd_ready, 0);
            if (apb && (k < x)) begin
                chk("paddr", paddr, e_addr);
                chk("pwrite", pwrite, e_wr);
                chk("pwdata", pwdata, e_wdata);
            end
            if (k >= x) begin
                chk("rsp_rdata", rsp_rdata, e_rd);
                chk("rsp_err", rsp_err, e_err);
            end
            if (psel) psel_n++;
            if (penable) pen_n++;
            if (rsp_valid) begin
                rv_n++;
                if (first_rv < 0) begin
                    first_rv = cyc;
                    cap_rd   = rsp_rdata;
                    cap_err  = rsp_err;
                end
            end
        end else begin
            chk("idle_psel", psel, 0);
            chk("idle_penable", penable, 0);
            chk("idle_rsp_valid", rsp_valid, 0);
            chk("idle_cmd_ready", cmd_ready, rdy_exp);
        end
    end

    task automatic accept_cmd(input bit w, input logic [31:0] a,
                              input logic [31:0] d, input int wt,
                              input bit st);
        int tries = 0;
        waits     = wt;
        stuck     = st;
        cmd_write = w;
        cmd_addr  = a;
        cmd_wdata = d;
        cmd_valid = 1'b1;
        forever begin
            @(posedge clk);
            tries++;
            if (rdy_exp && !act) break;
            if (tries > 50) begin
                $display("FAIL accept_wait: got none, expected accept");
                n_fail++;
                $fatal(1, "no accept");
            end
        end
        #1;
        cmd_valid = 1'b0;
        A         = cyc;
        e_addr    = a;
        e_wdata   = d;
        e_wr      = w;
        if (a[1:0] != 2'd0) begin
            apb = 0; x = 0; e_err = 1; e_rd = '0;
        end else if (st) begin
            apb = 1; x = 1 + TO; e_err = 1; e_rd = '0;
        end else begin
            apb = 1; x = 2 + wt; e_err = 0;
            e_rd = w ? 32'd0 : mmem[a[9:2]];
            if (w) mmem[a[9:2]] = d;
        end
        psel_n   = 0;
        pen_n    = 0;
        rv_n     = 0;
        first_rv = -1;
        act      = 1'b1;
    endtask

    task automatic finish_cmd(input int hold);
        int d_edge;
        rsp_ready = (hold == 0);
        d_edge    = A + x + 1 + hold;
        while (cyc < d_edge) begin
            @(posedge clk);
            #1;
            if (cyc == A + x + hold) rsp_ready = 1'b1;
        end
        act       = 1'b0;
        rsp_ready = 1'b1;
    endtask

    task automatic do_cmd(input bit w, input logic [31:0] a,
                          input logic [31:0] d, input int wt,
                          input bit st, input int hold);
        accept_cmd(w, a, d, wt, st);
        finish_cmd(hold);
    endtask

    task automatic release_rst();
        @(posedge clk);
        #2;
        rst_n   = 1'b1;
        in_rst  = 1'b0;
        rdy_exp = 1'b0;
        @(posedge clk);
        #1;
        rdy_exp = 1'b1;
        chk("ready_after_rst", cmd_ready, 1);
    endtask

    initial begin
        for (int i = 0; i < 256; i++) begin
            smem[i] = '0;
            mmem[i] = '0;
        end
        rst_n     = 1'b0;
        cmd_valid = 1'b0;
        cmd_write = 1'b0;
        cmd_addr  = '0;
        cmd_wdata = '0;
        rsp_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_cmd_ready", cmd_ready, 0);
        chk("reset_psel", psel, 0);
        chk("reset_rsp_valid", rsp_valid, 0);
        release_rst();

        do_cmd(1, 32'h4, 32'd500, 0, 0, 0);
        chk("wr_psel_cycles", psel_n, 2);
        chk("wr_penable_cycles", pen_n, 1);
        chk("wr_latency", first_rv - A + 1, 3);
        chk("wr_err", cap_err, 0);
        chk("wr_rdata", cap_rd, 0);

        do_cmd(0, 32'h4, 32'd0, 0, 0, 0);
        chk("rd_500", cap_rd, 500);
        do_cmd(1, 32'h4, 32'd128, 0, 0, 0);
        do_cmd(0, 32'h4, 32'd0, 0, 0, 0);
        chk("rd_128", cap_rd, 128);

        do_cmd(1, 32'h10, 32'hABCD, 3, 0, 0);
        chk("ws_penable_cycles", pen_n, 4);
        chk("ws_latency", first_rv - A + 1, 6);
        do_cmd(0, 32'h10, 32'd0, 2, 0, 0);
        chk("ws_rd", cap_rd, 32'hABCD);

        do_cmd(0, 32'h8, 32'd0, 0, 1, 0);
        chk("to_psel_cycles", psel_n, 17);
        chk("to_err", cap_err, 1);
        chk("to_rdata", cap_rd, 0);
        do_cmd(0, 32'h4, 32'd0, 0, 0, 0);
        chk("after_to_rd", cap_rd, 128);
        chk("after_to_err", cap_err, 0);

        do_cmd(1, 32'h6, 32'h77, 0, 0, 0);
        chk("mis_psel_cycles", psel_n, 0);
        chk("mis_latency", first_rv - A + 1, 1);
        chk("mis_err", cap_err, 1);

        accept_cmd(0, 32'hC, 32'd0, 0, 1);
        repeat (3) @(posedge clk);
        #3;
        rst_n  = 1'b0;
        in_rst = 1'b1;
        act    = 1'b0;
        #1;
        chk("async_psel", psel, 0);
        chk("async_penable", penable, 0);
        chk("async_rsp_valid", rsp_valid, 0);
        release_rst();
        stuck = 1'b0;

        do_cmd(1, 32'h20, 32'h55, 1, 0, 0);
        do_cmd(0, 32'h20, 32'd0, 0, 0, 5);
        chk("hold_rd", cap_rd, 32'h55);
        chk("hold_rv_cycles", rv_n, 6);

        for (int i = 0; i < 4; i++) begin
            do_cmd(1, 32'h40 + 32'(i * 4), 32'(i * 7 + 1), i % 2, 0, 0);
        end
        for (int i = 0; i < 4; i++) begin
            do_cmd(0, 32'h40 + 32'(i * 4), 32'd0, 0, 0, 0);
            chk("b2b_rd", cap_rd, 32'(i * 7 + 1));
        end

        repeat (2) @(posedge clk);
        $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
        $finish;
    end

endmodule
